dino_jump_master: RTL and testbench

- Avalon-MM write-only initiator that drives the dino VGA peripheral's register map (0 XCOOR, 1 YCOOR, 2 R, 3 G, 4 B).
- After reset it writes an initial configuration burst. On each frame tick it runs one step of jump/gravity physics, then writes the new dino Y to register 1.
- Sits between user input (debounced jump pulse) and the VGA peripheral's slave port.

---
 rtl/dino_pkg.sv | 20 ++
 rtl/dino_physics.sv | 57 +++++
 rtl/dino_jump_master.sv | 183 ++++++++++++++++++
 tb/tb_dino_jump_master.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared register map, FSM state type and coordinate/velocity types for the dino jump master.
package dino_pkg;

    localparam logic [2:0] REG_XCOOR = 3'd0;
    localparam logic [2:0] REG_YCOOR = 3'd1;
    localparam logic [2:0] REG_BG_R  = 3'd2;
    localparam logic [2:0] REG_BG_G  = 3'd3;
    localparam logic [2:0] REG_BG_B  = 3'd4;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        UPDATE,
        WRITE
    } dino_state_t;

    typedef logic [9:0]        ycoord_t;
    typedef logic signed [7:0] vel_t;

endpackage

// File: rtl/dino_physics.sv
// One frame of jump/gravity physics as a pure combinational function of the current
// position, velocity and jump request.
module dino_physics
    import dino_pkg::*;
#(
    parameter ycoord_t GROUND_Y = 10'd360,
    parameter vel_t    JUMP_VEL = -8'sd12,
    parameter vel_t    GRAVITY  = 8'sd1
) (
    input  logic [9:0] y_i,
    input  logic [7:0] vel_i,
    input  logic       airborne_i,
    input  logic       jump_pending_i,
    output logic [9:0] y_n_o,
    output logic [7:0] vel_n_o,
    output logic       airborne_n_o,
    output logic       consume_o
);

    logic signed [10:0] sum;
    logic signed [10:0] takeoff;
    logic signed [8:0]  vel_inc;
    vel_t               takeoff_vel;

    always_comb begin
        sum         = $signed({1'b0, y_i}) + $signed({{3{vel_i[7]}}, vel_i});
        takeoff     = $signed({1'b0, y_i}) + $signed({{3{JUMP_VEL[7]}}, JUMP_VEL});
        vel_inc     = $signed({vel_i[7], vel_i}) + $signed({GRAVITY[7], GRAVITY});
        takeoff_vel = JUMP_VEL + GRAVITY;

        y_n_o        = y_i;
        vel_n_o      = vel_i;
        airborne_n_o = airborne_i;
        consume_o    = 1'b0;

        if (!airborne_i && jump_pending_i) begin
            y_n_o        = takeoff[9:0];
            vel_n_o      = takeoff_vel;
            airborne_n_o = 1'b1;
            consume_o    = 1'b1;
        end else if (airborne_i) begin
            if (sum >= $signed({1'b0, GROUND_Y})) begin
                y_n_o        = GROUND_Y;
                vel_n_o      = '0;
                airborne_n_o = 1'b0;
            end else if (sum[10]) begin
                // Ceiling clamp: stop at the top edge but stay airborne so gravity resumes.
                y_n_o   = '0;
                vel_n_o = '0;
            end else begin
                y_n_o   = sum[9:0];
                vel_n_o = (vel_inc > 9'sd127) ? 8'sd127 : vel_inc[7:0];
            end
        end
    end

endmodule

// File: rtl/dino_jump_master.sv
// Avalon-MM write-only initiator: writes the init burst to the dino VGA peripheral, then
// steps the jump physics once per frame tick and writes the new Y to the YCOOR register.
module dino_jump_master
    import dino_pkg::*;
#(
    parameter ycoord_t    X_POS    = 10'd100,
    parameter ycoord_t    GROUND_Y = 10'd360,
    parameter vel_t       JUMP_VEL = -8'sd12,
    parameter vel_t       GRAVITY  = 8'sd1,
    parameter logic [7:0] BG_R     = 8'hFF,
    parameter logic [7:0] BG_G     = 8'hFF,
    parameter logic [7:0] BG_B     = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump,
    input  logic        frame_tick,
    input  logic        avm_waitrequest,
    output logic        avm_chipselect,
    output logic        avm_write,
    output logic [2:0]  avm_address,
    output logic [31:0] avm_writedata,
    output logic [9:0]  dino_y,
    output logic        airborne,
    output logic        init_done,
    output logic [7:0]  overrun
);

    dino_state_t state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    ycoord_t     y_q, y_d;
    vel_t        vel_q, vel_d;
    logic        air_q, air_d;
    logic        pend_q, pend_d;
    logic        done_q, done_d;
    logic [7:0]  ovr_q, ovr_d;
    logic        wr_q, wr_d;
    logic [2:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;

    logic [9:0]  phys_y;
    logic [7:0]  phys_vel;
    logic        phys_air;
    logic        phys_consume;

    dino_physics #(
        .GROUND_Y (GROUND_Y),
        .JUMP_VEL (JUMP_VEL),
        .GRAVITY  (GRAVITY)
    ) u_physics (
        .y_i            (y_q),
        .vel_i          (vel_q),
        .airborne_i     (air_q),
        .jump_pending_i (pend_q),
        .y_n_o          (phys_y),
        .vel_n_o        (phys_vel),
        .airborne_n_o   (phys_air),
        .consume_o      (phys_consume)
    );

    function automatic logic [31:0] init_word(input logic [2:0] idx);
        case (idx)
            REG_XCOOR: return {22'b0, X_POS};
            REG_YCOOR: return {22'b0, GROUND_Y};
            REG_BG_R:  return {24'b0, BG_R};
            REG_BG_G:  return {24'b0, BG_G};
            REG_BG_B:  return {24'b0, BG_B};
            default:   return '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            idx_q   <= '0;
            y_q     <= GROUND_Y;
            vel_q   <= '0;
            air_q   <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            air_q   <= air_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        y_d     = y_q;
        vel_d   = vel_q;
        air_d   = air_q;
        pend_d  = pend_q;
        done_d  = done_q;
        ovr_d   = ovr_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;

        // Requests seen while airborne or during the physics step itself are dropped.
        if (jump && !air_q && state_q != UPDATE) begin
            pend_d = 1'b1;
        end
        if (frame_tick && state_q != IDLE && ovr_q != 8'hFF) begin
            ovr_d = ovr_q + 8'd1;
        end

        unique case (state_q)
            INIT: begin
                if (!wr_q) begin
                    wr_d   = 1'b1;
                    addr_d = idx_q;
                    data_d = init_word(idx_q);
                end else if (!avm_waitrequest) begin
                    if (idx_q == REG_BG_B) begin
                        wr_d    = 1'b0;
                        addr_d  = '0;
                        data_d  = '0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Load the next word on the accepting edge so the burst has no bubbles.
                        idx_d  = idx_q + 3'd1;
                        addr_d = idx_q + 3'd1;
                        data_d = init_word(idx_q + 3'd1);
                    end
                end
            end
            IDLE: begin
                if (frame_tick) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                y_d   = phys_y;
                vel_d = phys_vel;
                air_d = phys_air;
                if (phys_consume) begin
                    pend_d = 1'b0;
                end
                wr_d    = 1'b1;
                addr_d  = REG_YCOOR;
                data_d  = {22'b0, phys_y};
                state_d = WRITE;
            end
            WRITE: begin
                if (!avm_waitrequest) begin
                    wr_d    = 1'b0;
                    addr_d  = '0;
                    data_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign avm_write      = wr_q;
    assign avm_chipselect = wr_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = data_q;
    assign dino_y         = y_q;
    assign airborne       = air_q;
    assign init_done      = done_q;
    assign overrun        = ovr_q;

endmodule

// File: tb/tb_dino_jump_master.sv
// Self-checking bench for dino_jump_master: directed init/overrun/reset steps plus randomized
// frames and jumps checked against a frame-level physics model.
module tb_dino_jump_master;

    localparam int GROUND = 360;
    localparam int JUMP   = -12;
    localparam int GRAV   = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        jump = 1'b0;
    logic        frame_tick = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic        avm_chipselect;
    logic        avm_write;
    logic [2:0]  avm_address;
    logic [31:0] avm_writedata;
    logic [9:0]  dino_y;
    logic        airborne;
    logic        init_done;
    logic [7:0]  overrun;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int addr2_cnt = 0;
    logic [34:0] wq[$];
    int          wcyc[$];

    // Reference model state
    int m_y = GROUND;
    int m_vel = 0;
    bit m_air = 1'b0;
    bit m_pending = 1'b0;
    int m_ovr = 0;

    dino_jump_master u_dut (
        .clk             (clk),
        .reset           (reset),
        .jump            (jump),
        .frame_tick      (frame_tick),
        .avm_waitrequest (avm_waitrequest),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .dino_y          (dino_y),
        .airborne        (airborne),
        .init_done       (init_done),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record writes that will be accepted on the coming rising edge.
    always @(negedge clk) begin
        if (!reset && avm_write && !avm_waitrequest) begin
            wq.push_back({avm_address, avm_writedata});
            wcyc.push_back(cyc);
        end
        if (!reset && avm_write && avm_address == 3'd2) addr2_cnt <= addr2_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_y = GROUND;
        m_vel = 0;
        m_air = 1'b0;
        m_pending = 1'b0;
        m_ovr = 0;
        wq.delete();
        wcyc.delete();
        addr2_cnt = 0;
    endtask

    task automatic model_frame();
        int s;
        if (!m_air && m_pending) begin
            m_y = m_y + JUMP;
            m_vel = JUMP + GRAV;
            m_air = 1'b1;
            m_pending = 1'b0;
        end else if (m_air) begin
            s = m_y + m_vel;
            if (s >= GROUND) begin
                m_y = GROUND;
                m_vel = 0;
                m_air = 1'b0;
            end else if (s < 0) begin
                m_y = 0;
                m_vel = 0;
            end else begin
                m_y = s;
                m_vel = (m_vel + GRAV > 127) ? 127 : m_vel + GRAV;
            end
        end
    endtask

    task automatic wait_init(output int done_cyc);
        int n = 0;
        while (!init_done && n < 60) begin
            step();
            n++;
        end
        done_cyc = cyc;
        check("init_done_timeout", 64'(init_done), 64'(1));
    endtask

    task automatic check_init_writes();
        logic [34:0] exp_w [5];
        exp_w[0] = {3'd0, 32'd100};
        exp_w[1] = {3'd1, 32'd360};
        exp_w[2] = {3'd2, 32'h0000_00FF};
        exp_w[3] = {3'd3, 32'h0000_00FF};
        exp_w[4] = {3'd4, 32'h0000_00FF};
        check("init_write_count", 64'(wq.size()), 64'(5));
        for (int i = 0; i < 5; i++) begin
            check("init_write", 64'((i < wq.size()) ? wq[i] : '1), 64'(exp_w[i]));
        end
    endtask

    task automatic pulse_jump();
        jump = 1'b1;
        if (!m_air) m_pending = 1'b1;
        step();
        jump = 1'b0;
    endtask

    task automatic do_frame(input bit coinc_jump, input bit upd_jump);
        int stalls;
        frame_tick = 1'b1;
        jump = coinc_jump;
        if (coinc_jump && !m_air) m_pending = 1'b1;
        step();
        frame_tick = 1'b0;
        jump = upd_jump;
        check("update_bus_idle", 64'(avm_write), 64'(0));
        model_frame();
        step();
        jump = 1'b0;
        check("frame_write", 64'(avm_write), 64'(1));
        check("frame_cs", 64'(avm_chipselect), 64'(1));
        check("frame_addr", 64'(avm_address), 64'(1));
        check("frame_data", 64'(avm_writedata), 64'(m_y));
        stalls = $urandom_range(0, 2);
        avm_waitrequest = (stalls != 0);
        for (int i = 0; i < stalls; i++) begin
            step();
            check("frame_hold", 64'({avm_write, avm_address, avm_writedata}),
                  64'({1'b1, 3'd1, 32'(m_y)}));
        end
        avm_waitrequest = 1'b0;
        step();
        check("frame_released", 64'(avm_write), 64'(0));
        check("frame_dino_y", 64'(dino_y), 64'(m_y));
        check("frame_airborne", 64'(airborne), 64'(m_air));
        check("frame_overrun", 64'(overrun), 64'(m_ovr));
        repeat ($urandom_range(0, 3)) step();
    endtask

    initial begin
        int done_cyc;
        int n;

        // Reset values
        reset = 1'b1;
        repeat (3) step();
        check("rst_write", 64'({avm_write, avm_chipselect}), 64'(0));
        check("rst_addr_data", 64'({avm_address, avm_writedata}), 64'(0));
        check("rst_dino_y", 64'(dino_y), 64'(GROUND));
        check("rst_flags", 64'({airborne, init_done}), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));

        // Unstalled init burst
        model_reset();
        reset = 1'b0;
        wait_init(done_cyc);
        check_init_writes();
        check("init_consecutive", 64'((wcyc.size() == 5) ? wcyc[4] - wcyc[0] : -1), 64'(4));
        check("init_done_timing", 64'(done_cyc), 64'((wcyc.size() == 5) ? wcyc[4] + 1 : -1));

        // Init burst stalled on idx 2
        reset = 1'b1;
        repeat (2) step();
        model_reset();
        reset = 1'b0;
        n = 0;
        while (!(avm_write && avm_address == 3'd2) && n < 20) begin
            step();
            n++;
        end
        check("stall_reach_idx2", 64'(avm_address), 64'(2));
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", 64'({avm_write, avm_address, avm_writedata}),
                  64'({1'b1, 3'd2, 32'h0000_00FF}));
        end
        avm_waitrequest = 1'b0;
        wait_init(done_cyc);
        check_init_writes();
        check("stall_idx2_cycles", 64'(addr2_cnt), 64'(4));

        // Idle frame with no jump
        step();
        do_frame(1'b0, 1'b0);
        check("idle_frame_y", 64'(dino_y), 64'(360));

        // Directed jump across 25 frames; a pulse before frame 5 is ignored while airborne
        pulse_jump();
        for (int f = 1; f <= 25; f++) begin
            if (f == 5) pulse_jump();
            do_frame(1'b0, 1'b0);
            if (f == 1) check("jump_f1", 64'(dino_y), 64'(348));
            if (f == 12 || f == 13) check("jump_apex", 64'(dino_y), 64'(282));
            if (f == 25) check("jump_land", 64'({airborne, dino_y}), 64'({1'b0, 10'd360}));
        end

        // Randomized frames and jumps (idle, coincident and during UPDATE)
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) pulse_jump();
            do_frame($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
        end

        // Dropped ticks during INIT and during a stalled WRITE
        reset = 1'b1;
        repeat (2) step();
        model_reset();
        reset = 1'b0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        m_ovr = 1;
        wait_init(done_cyc);
        check("ovr_init", 64'(overrun), 64'(1));
        check("ovr_init_writes", 64'(wq.size()), 64'(5));
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        model_frame();
        step();
        avm_waitrequest = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        check("ovr_stall_hold", 64'({avm_write, avm_address, avm_writedata}),
              64'({1'b1, 3'd1, 32'd360}));
        avm_waitrequest = 1'b0;
        repeat (3) step();
        check("ovr_count", 64'(overrun), 64'(2));
        check("ovr_write_count", 64'(wq.size()), 64'(6));
        check("ovr_bus_idle", 64'(avm_write), 64'(0));

        // Saturation, then reset while a WRITE is stalled
        m_ovr = 2;
        pulse_jump();
        for (int f = 0; f < 3; f++) do_frame(1'b0, 1'b0);
        check("pre_reset_y", 64'(dino_y), 64'(m_y));
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        model_frame();
        step();
        avm_waitrequest = 1'b1;
        frame_tick = 1'b1;
        repeat (300) step();
        frame_tick = 1'b0;
        check("ovr_saturate", 64'(overrun), 64'(255));
        check("sat_still_stalled", 64'(avm_write), 64'(1));
        reset = 1'b1;
        step();
        check("rst_mid_write", 64'({avm_write, avm_chipselect}), 64'(0));
        check("rst_mid_y", 64'(dino_y), 64'(360));
        check("rst_mid_ovr", 64'(overrun), 64'(0));
        check("rst_mid_flags", 64'({airborne, init_done}), 64'(0));
        model_reset();
        avm_waitrequest = 1'b0;
        reset = 1'b0;
        wait_init(done_cyc);
        check_init_writes();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
